// File: rtl/fir_dequant_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_dequant_mac
// Purpose  : Streaming multiply-accumulate with per-product dequantization.
//            Pops TAPS (sample, coefficient) pairs from an FWFT FIFO, divides
//            each product by 2^BITS (truncating toward zero) and pushes the
//            wrapped sum to a downstream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fir_dequant_mac #(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10,
    parameter int TAPS      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    input  logic [DATA_SIZE-1:0] x_in,
    input  logic [DATA_SIZE-1:0] coeff_in,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [DATA_SIZE-1:0] out_din
);

    localparam int c_prod_w = 2 * DATA_SIZE;
    localparam int c_cnt_w  = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [c_cnt_w-1:0]  c_last_tap = c_cnt_w'(TAPS - 1);
    localparam logic [c_prod_w-1:0] c_bias     = c_prod_w'((64'd1 << BITS) - 64'd1);

    localparam logic [0:0] c_s_acc = 1'b0;
    localparam logic [0:0] c_s_out = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [c_cnt_w-1:0]   r_count;
    logic [DATA_SIZE-1:0] r_acc;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_last_pop;

    logic [c_prod_w-1:0]  w_x_ext;
    logic [c_prod_w-1:0]  w_c_ext;
    logic [c_prod_w-1:0]  w_prod;
    logic [c_prod_w-1:0]  w_biased;
    logic [DATA_SIZE-1:0] w_deq;
    logic                 w_unused_bits;

    // Full-width signed product; a bias of 2^BITS-1 on negative products
    // turns the arithmetic shift into truncation toward zero.
    always_comb begin
        w_x_ext  = {{DATA_SIZE{x_in[DATA_SIZE-1]}}, x_in};
        w_c_ext  = {{DATA_SIZE{coeff_in[DATA_SIZE-1]}}, coeff_in};
        w_prod   = w_x_ext * w_c_ext;
        w_biased = w_prod + (w_prod[c_prod_w-1] ? c_bias : '0);
        // Bits [BITS +: DATA_SIZE] equal the low DATA_SIZE bits of (biased >>> BITS).
        w_deq    = w_biased[BITS +: DATA_SIZE];
        w_unused_bits = ^{w_biased[c_prod_w-1:BITS+DATA_SIZE], w_biased[BITS-1:0]};
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_s_acc;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: leave S_ACC on the TAPS-th pop, leave S_OUT on the push.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_acc: if (w_last_pop) w_state_next = c_s_out;
            c_s_out: if (w_push)     w_state_next = c_s_acc;
            default:                 w_state_next = c_s_acc;
        endcase
    end

    // Output decode; the pop is also masked by reset so nothing is consumed
    // while the block is held in reset.
    always_comb begin
        w_pop      = 1'b0;
        w_push     = 1'b0;
        out_din    = '0;
        case (r_state)
            c_s_acc: w_pop = !in_empty && !reset;
            c_s_out: begin
                w_push  = !out_full;
                out_din = r_acc;
            end
            default: ;
        endcase
        w_last_pop = w_pop && (r_count == c_last_tap);
        in_rd_en   = w_pop;
        out_wr_en  = w_push;
    end

    // Accumulator and tap counter; both hold across upstream empty gaps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_acc   <= '0;
        end else if (w_pop) begin
            r_acc   <= r_acc + w_deq;
            r_count <= w_last_pop ? '0 : r_count + 1'b1;
        end else if (w_push) begin
            r_acc   <= '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/fir_dequant_mac.md
# fir_dequant_mac

Streaming fixed-point multiply-accumulate with per-product dequantization for the FM radio datapath. Pops TAPS (sample, coefficient) pairs from an upstream first-word-fall-through FIFO, multiplies each pair, dequantizes each product by dividing by QUANT_VAL = 2^BITS with C-style truncation toward zero, and sums the results. One DATA_SIZE result per frame is pushed to a downstream FIFO. Sits between the quantized sample FIFOs and the filter output FIFOs; it is the fixed-point consumer of data produced by QUANTIZE_F, and its output matches software DEQUANTIZE bit-exactly.

## Interface
- DATA_SIZE, 32, width of samples, coefficients and result (two's complement)
- BITS, 10, quantization shift; QUANT_VAL = 1 << BITS
- TAPS, 8, pairs accumulated per output
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pop strobe; x_in/coeff_in consumed in the same cycle
- x_in  in  DATA_SIZE  signed sample (FWFT head)
- coeff_in  in  DATA_SIZE  signed coefficient (FWFT head)
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push strobe
- out_din  out  DATA_SIZE  signed accumulated result

## Operation
- States: S_ACC (accumulate) and S_OUT (emit). Registers: state, count (0..TAPS-1), acc (DATA_SIZE).
- S_ACC: in_rd_en = !in_empty. On each pop:
  - prod = x_in * coeff_in, signed, 2*DATA_SIZE bits.
  - deq = (prod + (prod<0 ? QUANT_VAL-1 : 0)) >>> BITS, truncated to DATA_SIZE. Result rounds toward zero, never toward -inf.
  - acc <= acc + deq, wrapping mod 2^DATA_SIZE with no saturation.
  - count increments. On the pop with count == TAPS-1: count <= 0, state <= S_OUT.
- S_OUT: in_rd_en = 0; out_din = acc; out_wr_en = !out_full. On the push: acc <= 0, state <= S_ACC.
- While out_full is high, hold S_OUT with out_din stable.
- in_rd_en and out_wr_en are combinational from state and the flags. They are never both high.
- No pop occurs on a cycle where in_empty = 1. acc and count hold across empty gaps.
- Reset values: state S_ACC, count 0, acc 0. Outputs during and after reset: in_rd_en 0 while reset is high, out_wr_en 0, out_din 0.
- Reset mid-frame discards the partial sum. The next TAPS pops form a fresh frame.

## Timing
- Each pop updates acc at the same clock edge; there is no multiplier pipeline stage.
- The edge that takes the TAPS-th pop moves state to S_OUT. out_wr_en is high in the next cycle if out_full = 0.
- Minimum frame period is TAPS+1 cycles: TAPS pops plus 1 push cycle. Peak throughput is one result per 9 cycles at default.
- Latency from the last pop edge to the push edge is 1 cycle plus any cycles out_full is held high.
- Upstream stalls add exactly one cycle per empty cycle.
- Deasserting reset takes effect on the first rising edge after reset falls.

## Test plan
- Ones frame: 8 pairs x=1024, coeff=1024, FIFO never empty. Required: in_rd_en high 8 consecutive cycles, then out_wr_en for 1 cycle with out_din=8192.
- Truncation toward zero: 8 pairs x=-3, coeff=512 (each product -1536 -> -1). Required: out_din=-8. Also 8 pairs x=-1, coeff=1. Required: out_din=0, not -8.
- Mixed signs and wrap: pairs alternating (2048,1024)->2048 and (-1024,1024)->-1024, 4 of each. Required: out_din=4096. Separately, 8 pairs each giving deq=0x40000000. Required: out_din wraps to 0.
- Input stalls: in_empty toggles every other cycle through a frame of 1024x1024 pairs. Required: exactly 8 pops, no pop while empty, out_din=8192, frame length 16 cycles plus 1 push cycle.
- Output backpressure: out_full held high 5 cycles at S_OUT entry. Required: out_wr_en low and in_rd_en low during those 5 cycles, out_din stable at 8192, push on the cycle out_full drops, then accumulation resumes with acc=0.
- Reset mid-frame: assert reset after 5 pops of 1024x1024, then deassert and feed 8 pairs of x=2048, coeff=1024. Required: outputs go to 0 immediately on reset assertion, and the single output is 16384 with no stale contribution.
